// File: rtl/myfunc_pkg.sv
// Shared definitions for the myfunc exhaustive sweeper.
//   VEC_W         - width of the {a,b,c,d} stimulus vector
//   MYFUNC_GOLDEN - expected myfunc output, bit i for vector i
//   sweep_state_t - sweeper FSM states
package myfunc_pkg;

    localparam int unsigned VEC_W         = 4;
    localparam logic [15:0] MYFUNC_GOLDEN = 16'hFF50;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/myfunc_sweeper_if.sv
// Handshake and cell-facing signals of the myfunc sweeper.
//   master : environment side (drives start, returns the cell output dut_o)
//   slave  : sweeper side (drives vec_out and the result/status signals)
// Optional: MYFUNC_SWEEP_MAP_EN adds the 16-bit per-vector fail_map.
interface myfunc_sweeper_if;

    logic                          start;
    logic                          dut_o;
    logic [myfunc_pkg::VEC_W-1:0]  vec_out;
    logic                          busy;
    logic                          done;
    logic                          pass;
    logic [4:0]                    err_cnt;
    logic [myfunc_pkg::VEC_W-1:0]  first_fail;
    logic                          first_fail_vld;
`ifdef MYFUNC_SWEEP_MAP_EN
    logic [15:0]                   fail_map;

    modport master (
        output start, dut_o,
        input  vec_out, busy, done, pass, err_cnt, first_fail, first_fail_vld, fail_map
    );
    modport slave (
        input  start, dut_o,
        output vec_out, busy, done, pass, err_cnt, first_fail, first_fail_vld, fail_map
    );
`else
    modport master (
        output start, dut_o,
        input  vec_out, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );
    modport slave (
        input  start, dut_o,
        output vec_out, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );
`endif

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter timing how long each vector is held before sampling.
//   clk, rst_n - clock, asynchronous active-low reset
//   load_i     - load SETTLE-1 (asserted on entry to APPLY)
//   expired_o  - count has reached zero
module settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic expired_o
);

    localparam logic [3:0] LoadVal = 4'(SETTLE - 1);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LoadVal;
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 4'd0);

endmodule

// File: rtl/myfunc_sweeper.sv
// Exhaustive driver/checker for the 4-input myfunc cell: applies all 16 vectors,
// holds each SETTLE cycles, samples the cell output and compares with GOLDEN.
//   clk, rst_n - clock, asynchronous active-low reset
//   sw_io      - myfunc_sweeper_if.slave: start/dut_o in; vec_out, busy, done,
//                pass, err_cnt, first_fail, first_fail_vld out
// Optional: MYFUNC_SWEEP_MAP_EN adds fail_map (bit i set when vector i failed).
module myfunc_sweeper
    import myfunc_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter logic [15:0] GOLDEN = MYFUNC_GOLDEN
) (
    input  logic             clk,
    input  logic             rst_n,
    myfunc_sweeper_if.slave  sw_io
);

    sweep_state_t     state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [4:0]       err_q, err_d;
    logic [VEC_W-1:0] ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic             pass_q, pass_d;
    logic             load;
    logic             expired;
    logic             mismatch;
`ifdef MYFUNC_SWEEP_MAP_EN
    logic [15:0]      map_q, map_d;
`endif

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .expired_o (expired)
    );

    // Case inequality so an X/Z from the cell is reported as a failure.
    assign mismatch = (sw_io.dut_o !== GOLDEN[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        load    = 1'b0;
`ifdef MYFUNC_SWEEP_MAP_EN
        map_d   = map_q;
`endif
        unique case (state_q)
            IDLE: begin
                vec_d = '0;
                if (sw_io.start) begin
                    state_d = APPLY;
                    load    = 1'b1;
                    err_d   = 5'd0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
`ifdef MYFUNC_SWEEP_MAP_EN
                    map_d   = 16'h0000;
`endif
                end
            end
            APPLY: begin
                if (expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (!ffv_q) begin
                        ff_d  = vec_q;
                        ffv_d = 1'b1;
                    end
`ifdef MYFUNC_SWEEP_MAP_EN
                    map_d[vec_q] = 1'b1;
`endif
                end
                if (vec_q == 4'hF) begin
                    state_d = DONE;
                    // Uses err_d so the last vector's result is included.
                    pass_d  = (err_d == 5'd0);
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + 4'd1;
                    load    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                vec_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= 5'd0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
`ifdef MYFUNC_SWEEP_MAP_EN
            map_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
`ifdef MYFUNC_SWEEP_MAP_EN
            map_q   <= map_d;
`endif
        end
    end

    assign sw_io.vec_out        = vec_q;
    assign sw_io.busy           = (state_q == APPLY) || (state_q == SAMPLE);
    assign sw_io.done           = (state_q == DONE);
    assign sw_io.pass           = pass_q;
    assign sw_io.err_cnt        = err_q;
    assign sw_io.first_fail     = ff_q;
    assign sw_io.first_fail_vld = ffv_q;
`ifdef MYFUNC_SWEEP_MAP_EN
    assign sw_io.fail_map       = map_q;
`endif

endmodule

// File: tb/tb_myfunc_sweeper.sv
// Self-checking bench for myfunc_sweeper: table of cell behaviours with a
// scoreboard of expected sweep results, plus reset-abort, start-while-busy and
// back-to-back sequences.
module tb_myfunc_sweeper;
    import myfunc_pkg::*;

    localparam int S1  = 2;
    localparam int S2  = 1;
    localparam int LAT1 = 16 * (S1 + 1) + 1;  // negedges from start-accept to done
    localparam int PER2 = 16 * (S2 + 1) + 2;

    // Cell behaviours: 0 correct, 1 stuck at 0, 2 X on vector 9, 3 inverted
    typedef struct {
        int          mode;
        logic [4:0]  err;
        logic [3:0]  ff;
        logic        ffv;
        logic        pass;
        logic [15:0] map;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   mode1 = 0;
    int   mode2 = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t sb[$];
    vec_t tbl[4];

    always #5 clk = ~clk;

    myfunc_sweeper_if if1();
    myfunc_sweeper_if if2();

    myfunc_sweeper #(.SETTLE(S1), .GOLDEN(MYFUNC_GOLDEN)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_io (if1)
    );
    myfunc_sweeper #(.SETTLE(S2), .GOLDEN(MYFUNC_GOLDEN)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_io (if2)
    );

    function automatic logic cell_o(input int mode, input logic [3:0] v);
        logic [15:0] g;
        g = 16'hFF50;
        case (mode)
            1:       return 1'b0;
            2:       return (v == 4'd9) ? 1'bx : g[v];
            3:       return ~g[v];
            default: return g[v];
        endcase
    endfunction

    always_comb if1.dut_o = cell_o(mode1, if1.vec_out);
    always_comb if2.dut_o = cell_o(mode2, if2.vec_out);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero1(input string tag);
        check({tag, "_vec"}, 32'(if1.vec_out), 0);
        check({tag, "_busy"}, 32'(if1.busy), 0);
        check({tag, "_done"}, 32'(if1.done), 0);
        check({tag, "_pass"}, 32'(if1.pass), 0);
        check({tag, "_err"}, 32'(if1.err_cnt), 0);
        check({tag, "_ff"}, 32'(if1.first_fail), 0);
        check({tag, "_ffv"}, 32'(if1.first_fail_vld), 0);
`ifdef MYFUNC_SWEEP_MAP_EN
        check({tag, "_map"}, 32'(if1.fail_map), 0);
`endif
    endtask

    // One sweep on DUT1; optional extra start pulse at negedge pulse_k.
    task automatic sweep1(input int mode, input int pulse_k);
        int   k;
        int   extra;
        bit   seen;
        vec_t e;
        mode1 = mode;
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        check("busy_rise", 32'(if1.busy), 1);
        k = 1;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            if (if1.done) begin
                seen = 1'b1;
            end else begin
                check("vec_out", 32'(if1.vec_out), 32'((k - 1) / (S1 + 1)));
                @(negedge clk);
                if1.start = (pulse_k != 0 && k == pulse_k);
                k++;
            end
        end
        if1.start = 1'b0;
        check("done_latency", 32'(k), 32'(LAT1));
        check("busy_at_done", 32'(if1.busy), 0);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check("err_cnt", 32'(if1.err_cnt), 32'(e.err));
            check("first_fail", 32'(if1.first_fail), 32'(e.ff));
            check("first_fail_vld", 32'(if1.first_fail_vld), 32'(e.ffv));
            check("pass", 32'(if1.pass), 32'(e.pass));
`ifdef MYFUNC_SWEEP_MAP_EN
            check("fail_map", 32'(if1.fail_map), 32'(e.map));
`endif
            // Results must hold and no further sweep may start on its own.
            extra = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (if1.done || if1.busy) extra++;
            end
            check("no_extra_sweep", 32'(extra), 0);
            check("hold_vec", 32'(if1.vec_out), 0);
            check("hold_err", 32'(if1.err_cnt), 32'(e.err));
            check("hold_pass", 32'(if1.pass), 32'(e.pass));
            check("hold_ff", 32'(if1.first_fail), 32'(e.ff));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int dones;
        int last_t;
        bit prev_busy;

        tbl[0] = '{mode: 0, err: 5'd0,  ff: 4'd0, ffv: 1'b0, pass: 1'b1, map: 16'h0000};
        tbl[1] = '{mode: 1, err: 5'd10, ff: 4'd4, ffv: 1'b1, pass: 1'b0, map: 16'hFF50};
        tbl[2] = '{mode: 2, err: 5'd1,  ff: 4'd9, ffv: 1'b1, pass: 1'b0, map: 16'h0200};
        tbl[3] = '{mode: 3, err: 5'd16, ff: 4'd0, ffv: 1'b1, pass: 1'b0, map: 16'hFFFF};

        if1.start = 1'b0;
        if2.start = 1'b0;
        repeat (2) @(negedge clk);
        check_zero1("reset");
        check("reset_dut2_busy", 32'(if2.busy), 0);
        check("reset_dut2_vec", 32'(if2.vec_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            sb.push_back(tbl[i]);
            sweep1(tbl[i].mode, 0);
        end

        // Leave failure results in place so the abort must clear them.
        sb.push_back(tbl[1]);
        sweep1(1, 0);

        // Reset mid-sweep at vector 7.
        mode1 = 0;
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        w = 0;
        while (if1.vec_out != 4'd7 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("reach_vec7", 32'(w < 200), 1);
        rst_n = 1'b0;
        #1;
        check_zero1("abort");
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 5) rst_n = 1'b1;
            if (if1.done) dones++;
        end
        check("abort_no_done", 32'(dones), 0);
        sb.push_back(tbl[0]);
        sweep1(0, 0);

        // Start pulse while busy is ignored.
        sb.push_back(tbl[1]);
        sweep1(1, 20);

        // Back-to-back sweeps on DUT2 with start held high.
        mode2 = 1;
        @(negedge clk);
        if2.start = 1'b1;
        dones = 0;
        last_t = 0;
        prev_busy = 1'b0;
        for (int k = 1; k <= 3 * PER2 + 10; k++) begin
            @(negedge clk);
            if (if2.busy && !prev_busy && dones > 0) begin
                check("b2b_err_clear", 32'(if2.err_cnt), 0);
            end
            if (if2.done) begin
                check("b2b_err", 32'(if2.err_cnt), 10);
                check("b2b_pass", 32'(if2.pass), 0);
                if (dones > 0) check("b2b_period", 32'(k - last_t), 32'(PER2));
                dones++;
                last_t = k;
            end
            prev_busy = if2.busy;
        end
        if2.start = 1'b0;
        check("b2b_done_count", 32'(dones), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
